// File: rtl/flatten_buffer_if.sv
// Bundle between the pooled-fmap producer / FC consumer and the flatten buffer.
// The slave modport is the buffer itself; the master modport is its environment.
interface flatten_buffer_if #(
    parameter int DATA_WIDTH       = 8,
    parameter int FLATTENED_LENGTH = 432,
    parameter int IDX_WIDTH        = $clog2(FLATTENED_LENGTH)
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_data;
    logic                         in_last;
    logic                         fc_done;
    logic signed [DATA_WIDTH-1:0] flattened_outfmap [FLATTENED_LENGTH];
    logic                         fullyconnect_start;
    logic [IDX_WIDTH-1:0]         wr_index;
    logic                         frame_error;
    logic [15:0]                  frames_done;

    modport slave (
        input  in_valid, in_data, in_last, fc_done,
        output in_ready, flattened_outfmap, fullyconnect_start,
               wr_index, frame_error, frames_done
    );

    modport master (
        output in_valid, in_data, in_last, fc_done,
        input  in_ready, flattened_outfmap, fullyconnect_start,
               wr_index, frame_error, frames_done
    );
endinterface

// File: rtl/flatten_buffer.sv
// Flatten buffer: gathers one pooled feature map (channel, row, column order)
// into a register array and presents it to the FC stage until it acknowledges.
//
//  state  | meaning
//  S_FILL | accepting elements, writing the array at wr_index
//  S_HOLD | array complete and frozen, fullyconnect_start high, waiting fc_done
module flatten_buffer #(
    parameter int NUM_CHANNELS     = 3,
    parameter int FMAP_H           = 12,
    parameter int FMAP_W           = 12,
    parameter int FLATTENED_LENGTH = NUM_CHANNELS * FMAP_H * FMAP_W,
    parameter int DATA_WIDTH       = 8,
    parameter int IDX_WIDTH        = $clog2(FLATTENED_LENGTH)
) (
    input  logic             clk,
    input  logic             reset,
    flatten_buffer_if.slave  bus
);
    typedef enum logic [0:0] {S_FILL, S_HOLD} state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(FLATTENED_LENGTH - 1);

    state_t                       r_state;
    logic [IDX_WIDTH-1:0]         r_wr_index;
    logic                         r_start;
    logic                         r_frame_error;
    logic [15:0]                  r_frames_done;
    logic signed [DATA_WIDTH-1:0] r_array [FLATTENED_LENGTH];

    logic w_ready;
    logic w_accept;
    logic w_at_last_idx;

    // Ready is gated by reset directly so nothing is accepted while reset is held.
    assign w_ready       = (r_state == S_FILL) && !reset;
    assign w_accept      = bus.in_valid && w_ready;
    assign w_at_last_idx = (r_wr_index == LAST_IDX);

    // Sequencing FSM: write pointer, start handshake, frame bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_FILL;
            r_wr_index    <= '0;
            r_start       <= 1'b0;
            r_frame_error <= 1'b0;
            r_frames_done <= 16'd0;
        end else begin
            r_frame_error <= 1'b0;
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        if (w_at_last_idx) begin
                            // Length reached: the frame completes whether or not
                            // the marker came, but a missing marker is flagged.
                            r_state       <= S_HOLD;
                            r_start       <= 1'b1;
                            r_wr_index    <= '0;
                            r_frames_done <= r_frames_done + 16'd1;
                            r_frame_error <= !bus.in_last;
                        end else if (bus.in_last) begin
                            // Short frame: discard the partial count and restart.
                            r_wr_index    <= '0;
                            r_frame_error <= 1'b1;
                        end else begin
                            r_wr_index <= r_wr_index + IDX_WIDTH'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.fc_done) begin
                        r_state <= S_FILL;
                        r_start <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_FILL;
                    r_start <= 1'b0;
                end
            endcase
        end
    end

    // Element storage: written only on accept, which cannot happen in HOLD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < FLATTENED_LENGTH; k++) begin
                r_array[k] <= '0;
            end
        end else if (w_accept) begin
            r_array[r_wr_index] <= bus.in_data;
        end
    end

    assign bus.in_ready           = w_ready;
    assign bus.fullyconnect_start = r_start;
    assign bus.wr_index           = r_wr_index;
    assign bus.frame_error        = r_frame_error;
    assign bus.frames_done        = r_frames_done;

    for (genvar g = 0; g < FLATTENED_LENGTH; g++) begin : g_out
        assign bus.flattened_outfmap[g] = r_array[g];
    end
endmodule

// File: tb/tb_flatten_buffer.sv
// Bench for flatten_buffer: element scoreboard compared against the array at start.
module tb_flatten_buffer;
    localparam int LEN = 432;
    localparam int DW  = 8;
    localparam int IW  = $clog2(LEN);

    logic clk;
    logic reset;

    flatten_buffer_if #(.DATA_WIDTH(DW), .FLATTENED_LENGTH(LEN), .IDX_WIDTH(IW)) bus ();

    flatten_buffer #(
        .NUM_CHANNELS(3), .FMAP_H(12), .FMAP_W(12),
        .FLATTENED_LENGTH(LEN), .DATA_WIDTH(DW), .IDX_WIDTH(IW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int err_seen = 0;

    logic signed [DW-1:0] sb_q [$];
    logic signed [DW-1:0] m_last [LEN];
    int                   m_idx = 0;
    logic [15:0]          m_frames = 16'd0;
    logic                 m_full = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) if (bus.frame_error === 1'b1) err_seen++;

    // Drive one element, wait for acceptance, update the model and check status
    // just after the accepting edge (start latency is exactly that edge).
    task automatic send(input logic signed [DW-1:0] d, input logic last, input bit gaps);
        int  n;
        logic fe;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) break;
            n++;
            if (n > 1000) begin
                check("accept_timeout", 32'd0, 32'd1);
                bus.in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        sb_q.push_back(d);
        fe = 1'b0;
        if (m_idx == LEN - 1) begin
            m_idx = 0;
            m_frames++;
            m_full = 1'b1;
            fe = !last;
        end else if (last) begin
            m_idx = 0;
            fe = 1'b1;
            sb_q.delete();
        end else begin
            m_idx++;
        end
        check("wr_index", 32'(bus.wr_index), 32'(m_idx));
        check("start", 32'(bus.fullyconnect_start), 32'(m_full));
        check("frame_error", 32'(bus.frame_error), 32'(fe));
        check("frames_done", 32'(bus.frames_done), 32'(m_frames));
    endtask

    task automatic check_frame();
        logic signed [DW-1:0] e;
        check("sb_count", 32'(sb_q.size()), 32'(LEN));
        for (int k = 0; k < LEN; k++) begin
            e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
            m_last[k] = e;
            check($sformatf("arr[%0d]", k), 32'(bus.flattened_outfmap[k]), 32'(e));
        end
    endtask

    task automatic release_hold();
        bus.fc_done = 1'b1;
        @(posedge clk); #1;
        bus.fc_done = 1'b0;
        m_full = 1'b0;
        check("rel_start", 32'(bus.fullyconnect_start), 32'd0);
        check("rel_ready", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        int nz;
        nz = 0;
        for (int k = 0; k < LEN; k++) if (bus.flattened_outfmap[k] !== '0) nz++;
        check({tag, "_arr_nonzero"}, 32'(nz), 32'd0);
        check({tag, "_start"}, 32'(bus.fullyconnect_start), 32'd0);
        check({tag, "_wr_index"}, 32'(bus.wr_index), 32'd0);
        check({tag, "_frames"}, 32'(bus.frames_done), 32'd0);
        check({tag, "_ferr"}, 32'(bus.frame_error), 32'd0);
        check({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_idx = 0;
        m_frames = 16'd0;
        m_full = 1'b0;
    endtask

    initial begin
        int diffs;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        bus.fc_done  = 1'b0;
        #12;
        check_reset_state("por");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: back-to-back frame 0..431
        for (int i = 0; i < LEN; i++) send(DW'(i), i == LEN - 1, 1'b0);
        check_frame();
        release_hold();

        // 2: same frame with random valid gaps
        for (int i = 0; i < LEN; i++) send(DW'(i), i == LEN - 1, 1'b1);
        check_frame();

        // 3: back-pressure in HOLD
        bus.in_valid = 1'b1;
        bus.in_data  = 8'sh7F;
        bus.in_last  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("hold_ready", 32'(bus.in_ready), 32'd0);
            diffs = 0;
            for (int k = 0; k < LEN; k++) if (bus.flattened_outfmap[k] !== m_last[k]) diffs++;
            check("hold_arr_diff", 32'(diffs), 32'd0);
            check("hold_start", 32'(bus.fullyconnect_start), 32'd1);
        end
        @(posedge clk); #1;
        release_hold();
        send(8'sh7F, 1'b0, 1'b0);
        check("entry0_7f", 32'(bus.flattened_outfmap[0]), 32'(8'sh7F));

        // 4: short frame ending at element 99, then a normal frame
        for (int i = 1; i < 100; i++) send(DW'(i), i == 99, 1'b0);
        @(posedge clk); #1;
        check("short_ferr_pulse", 32'(bus.frame_error), 32'd0);
        check("short_no_start", 32'(bus.fullyconnect_start), 32'd0);
        for (int i = 0; i < LEN; i++) send(DW'(i * 3 + 5), i == LEN - 1, 1'b0);
        check_frame();
        release_hold();

        // 5: full frame with no in_last marker
        for (int i = 0; i < LEN; i++) send(DW'(~i), 1'b0, 1'b0);
        check_frame();
        release_hold();

        // 6: reset mid-frame, then in HOLD
        for (int i = 0; i < 200; i++) send(DW'(i + 17), 1'b0, 1'b0);
        check("pre_reset_idx", 32'(bus.wr_index), 32'd200);
        #2 reset = 1'b1;
        #1 check_reset_state("rst_mid");
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < LEN; i++) send(DW'(LEN - i), i == LEN - 1, 1'b1);
        check_frame();
        #2 reset = 1'b1;
        #1 check_reset_state("rst_hold");
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(bus.in_ready), 32'd1);

        check("err_pulses", 32'(err_seen), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
